jtag_scan_master: RTL and testbench

- Host-side JTAG initiator that drives a TAP: generates tck/tms/tdi and captures tdo.
- Complements the CPU debug-slave virtual JTAG responder, for on-chip self-test and scripted debug access without an external cable.
- Accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready interface.
- Returns captured TDO bits over a valid/ready response interface.

---
 rtl/jtag_scan_master.sv | 212 +++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator issuing IR/DR scans and TAP resets from a command queue
// Drives tck/tms/tdi from a clk divider and returns captured tdo bits over a valid/ready response.
module jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 38
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_TLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_HDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t             state_q;
    logic [DW-1:0]      div_q;
    logic [5:0]         bit_q;
    logic [5:0]         len_q;
    logic [MAX_LEN-1:0] sh_q;
    logic               ir_q;
    logic               tlr_rsp_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               rsp_err_q;
    logic               busy_q;

    logic [5:0]         bit_d;
    logic [5:0]         hdr_last_d;
    logic               hdr_tms_d;
    logic [MAX_LEN-1:0] capture_d;
    logic               cmd_bad_d;

    always_comb begin
        bit_d      = bit_q + 6'd1;
        hdr_last_d = ir_q ? 6'd3 : 6'd2;
        // Header walks Select-DR(, Select-IR), Capture, Shift from Run-Test/Idle.
        hdr_tms_d  = ir_q ? (bit_d < 6'd2) : (bit_d == 6'd0);
        capture_d  = {{(MAX_LEN-1){1'b0}}, tdo} << bit_q;
        cmd_bad_d  = (cmd_len == 6'd0) || (cmd_len > LEN_MAX) || (cmd_op == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_TLR;
            div_q       <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            sh_q        <= '0;
            ir_q        <= 1'b0;
            tlr_rsp_q   <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        len_q       <= cmd_len;
                        sh_q        <= cmd_data;
                        ir_q        <= cmd_op[0];
                        bit_q       <= '0;
                        div_q       <= '0;
                        tck_q       <= 1'b0;
                        if (cmd_bad_d) begin
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (cmd_op == 2'b10) begin
                            state_q   <= S_TLR;
                            tlr_rsp_q <= 1'b1;
                            tms_q     <= 1'b1;
                        end else begin
                            state_q <= S_HDR;
                            tms_q   <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        tck_q <= ~tck_q;
                        if (!tck_q) begin
                            if (state_q == S_SHIFT) begin
                                rsp_data_q <= rsp_data_q | capture_d;
                            end
                        end else begin
                            // Falling tck edge: finish the current bit and set up tms/tdi for the next.
                            case (state_q)
                                S_TLR: begin
                                    if (bit_q == 6'd5) begin
                                        tlr_rsp_q <= 1'b0;
                                        tms_q     <= 1'b0;
                                        bit_q     <= '0;
                                        if (tlr_rsp_q) begin
                                            state_q     <= S_RSP;
                                            rsp_valid_q <= 1'b1;
                                        end else begin
                                            state_q     <= S_IDLE;
                                            cmd_ready_q <= 1'b1;
                                            busy_q      <= 1'b0;
                                        end
                                    end else begin
                                        bit_q <= bit_d;
                                        tms_q <= (bit_d < 6'd5);
                                    end
                                end

                                S_HDR: begin
                                    if (bit_q == hdr_last_d) begin
                                        state_q <= S_SHIFT;
                                        bit_q   <= '0;
                                        tdi_q   <= sh_q[0];
                                        sh_q    <= sh_q >> 1;
                                        tms_q   <= (len_q == 6'd1);
                                    end else begin
                                        bit_q <= bit_d;
                                        tms_q <= hdr_tms_d;
                                    end
                                end

                                S_SHIFT: begin
                                    if (bit_q == len_q - 6'd1) begin
                                        state_q <= S_TAIL;
                                        bit_q   <= '0;
                                        tms_q   <= 1'b1;
                                        tdi_q   <= 1'b0;
                                    end else begin
                                        bit_q <= bit_d;
                                        tdi_q <= sh_q[0];
                                        sh_q  <= sh_q >> 1;
                                        tms_q <= (bit_d == len_q - 6'd1);
                                    end
                                end

                                default: begin
                                    tms_q <= 1'b0;
                                    tdi_q <= 1'b0;
                                    if (bit_q == 6'd1) begin
                                        state_q     <= S_RSP;
                                        bit_q       <= '0;
                                        rsp_valid_q <= 1'b1;
                                    end else begin
                                        bit_q <= bit_d;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed self-checking bench for jtag_scan_master
// Logs tms/tdi on every tck rise; tdo comes from a constant or a one-stage loopback register.
module tb_jtag_scan_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_data;
    logic        rsp_err;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        busy;

    logic        tdo_mode = 1'b0;
    logic        tdo_const = 1'b0;
    logic        model_q = 1'b0;
    int          rise_total = 0;
    logic        tms_log [0:4095];
    logic        tdi_log [0:4095];
    int          base = 0;

    int          vec_cnt = 0;
    int          err_cnt = 0;

    jtag_scan_master #(.CLK_DIV(2), .MAX_LEN(38)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign tdo = tdo_mode ? model_q : tdo_const;

    always @(posedge tck) begin
        tms_log[rise_total % 4096] <= tms;
        tdi_log[rise_total % 4096] <= tdi;
        model_q    <= tdi;
        rise_total <= rise_total + 1;
    end

    function automatic logic [63:0] tms_pattern(input int first, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = tms_log[(first + i) % 4096];
        return v;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [37:0] data);
        int t;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 within 200 clks", cmd_ready);
        end
        base = rise_total;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) n = -1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_tlr(output int n, output int vseen);
        n = 0;
        vseen = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) vseen++;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic check_reset_values(input string tag);
        vec_cnt++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy} !== 7'b0100001 || rsp_data !== 38'h0) begin
            err_cnt++;
            $display("FAIL %s: tck/tms/tdi/rdy/rv/err/busy=%b%b%b%b%b%b%b data=%h required 0100001 data=0",
                     tag, tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy, rsp_data);
        end
    endtask

    task automatic test_reset();
        int n, vs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        base = rise_total;
        reset = 1'b0;
        wait_tlr(n, vs);
        vec_cnt++;
        if (n !== 24) begin err_cnt++; $display("FAIL tlr_busy_clks: got %0d required 24", n); end
        vec_cnt++;
        if (rise_total - base !== 6) begin err_cnt++; $display("FAIL tlr_rises: got %0d required 6", rise_total - base); end
        vec_cnt++;
        if (tms_pattern(base, 6) !== 64'h1F) begin
            err_cnt++; $display("FAIL tlr_tms: got %h required 1f", tms_pattern(base, 6));
        end
        vec_cnt++;
        if (cmd_ready !== 1'b1 || tck !== 1'b0) begin
            err_cnt++; $display("FAIL tlr_idle: cmd_ready=%b tck=%b required 1 0", cmd_ready, tck);
        end
    endtask

    task automatic test_ir_scan();
        int n;
        tdo_mode  = 1'b0;
        tdo_const = 1'b1;
        send_cmd(2'b01, 6'd2, 38'h2);
        wait_rsp(n);
        vec_cnt++;
        if (n !== 32) begin err_cnt++; $display("FAIL ir_latency: got %0d clks required 32", n); end
        vec_cnt++;
        if (rise_total - base !== 8) begin err_cnt++; $display("FAIL ir_rises: got %0d required 8", rise_total - base); end
        vec_cnt++;
        if (tms_pattern(base, 8) !== 64'h63) begin
            err_cnt++; $display("FAIL ir_tms: got %h required 63", tms_pattern(base, 8));
        end
        vec_cnt++;
        if ({tdi_log[(base + 4) % 4096], tdi_log[(base + 5) % 4096]} !== 2'b01) begin
            err_cnt++; $display("FAIL ir_tdi: got %b%b required 01", tdi_log[(base + 4) % 4096], tdi_log[(base + 5) % 4096]);
        end
        vec_cnt++;
        if (rsp_data !== 38'h3 || rsp_err !== 1'b0) begin
            err_cnt++; $display("FAIL ir_rsp: data=%h err=%b required 3 0", rsp_data, rsp_err);
        end
        ack_rsp();
        vec_cnt++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            err_cnt++; $display("FAIL ir_ack: rsp_valid=%b cmd_ready=%b required 0 0", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL ir_ready_next: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_dr_scan();
        int n;
        logic [37:0] tdi_got;
        tdo_mode = 1'b1;
        send_cmd(2'b00, 6'd38, 38'h2A_5A5A_5A5A);
        wait_rsp(n);
        vec_cnt++;
        if (n !== 172) begin err_cnt++; $display("FAIL dr_latency: got %0d clks required 172", n); end
        vec_cnt++;
        if (rise_total - base !== 43) begin err_cnt++; $display("FAIL dr_rises: got %0d required 43", rise_total - base); end
        for (int i = 0; i < 38; i++) tdi_got[i] = tdi_log[(base + 3 + i) % 4096];
        vec_cnt++;
        if (tdi_got !== 38'h2A_5A5A_5A5A) begin
            err_cnt++; $display("FAIL dr_tdi: got %h required 2a5a5a5a5a", tdi_got);
        end
        vec_cnt++;
        if (tms_log[(base + 40) % 4096] !== 1'b1 || tms_log[(base + 39) % 4096] !== 1'b0) begin
            err_cnt++; $display("FAIL dr_exit_tms: last=%b prev=%b required 1 0",
                                tms_log[(base + 40) % 4096], tms_log[(base + 39) % 4096]);
        end
        vec_cnt++;
        if (rsp_data !== 38'h14_B4B4_B4B4 || rsp_err !== 1'b0) begin
            err_cnt++; $display("FAIL dr_rsp: data=%h err=%b required 14b4b4b4b4 0", rsp_data, rsp_err);
        end
        ack_rsp();
        @(negedge clk);
        tdo_mode = 1'b0;
    endtask

    task automatic test_errors();
        int n;
        logic [1:0] ops  [3] = '{2'b00, 2'b11, 2'b01};
        logic [5:0] lens [3] = '{6'd0, 6'd4, 6'd39};
        for (int k = 0; k < 3; k++) begin
            send_cmd(ops[k], lens[k], 38'h3F_FFFF_FFFF);
            wait_rsp(n);
            vec_cnt++;
            if (n !== 0 || rsp_err !== 1'b1 || rsp_data !== 38'h0 || rise_total !== base) begin
                err_cnt++;
                $display("FAIL err_cmd%0d: clks=%0d err=%b data=%h rises=%0d required 0 1 0 0",
                         k, n, rsp_err, rsp_data, rise_total - base);
            end
            ack_rsp();
            @(negedge clk);
        end
    endtask

    task automatic test_tap_reset();
        int n;
        send_cmd(2'b10, 6'd5, 38'h1);
        wait_rsp(n);
        vec_cnt++;
        if (n !== 24 || rise_total - base !== 6) begin
            err_cnt++; $display("FAIL tapreset_len: clks=%0d rises=%0d required 24 6", n, rise_total - base);
        end
        vec_cnt++;
        if (tms_pattern(base, 6) !== 64'h1F || rsp_err !== 1'b0 || rsp_data !== 38'h0) begin
            err_cnt++; $display("FAIL tapreset_rsp: tms=%h err=%b data=%h required 1f 0 0",
                                tms_pattern(base, 6), rsp_err, rsp_data);
        end
        ack_rsp();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, bad, held;
        tdo_const = 1'b1;
        send_cmd(2'b00, 6'd4, 38'h6);
        wait_rsp(n);
        vec_cnt++;
        if (n !== 36 || rsp_data !== 38'hF) begin
            err_cnt++; $display("FAIL hold_first: clks=%0d data=%h required 36 f", n, rsp_data);
        end
        held = rise_total;
        cmd_op = 2'b01; cmd_len = 6'd3; cmd_data = 38'h5; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 38'hF || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        vec_cnt++;
        if (bad !== 0 || rise_total !== held) begin
            err_cnt++; $display("FAIL hold_stable: bad_cycles=%0d rises=%0d required 0 0", bad, rise_total - held);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vec_cnt++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            err_cnt++; $display("FAIL hold_release: rsp_valid=%b cmd_ready=%b required 0 0", rsp_valid, cmd_ready);
        end
        base = rise_total;
        @(negedge clk);
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL hold_next_ready: got %b required 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        vec_cnt++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL hold_accept: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
        end
        wait_rsp(n);
        vec_cnt++;
        if (n !== 36 || rsp_data !== 38'h7 || rise_total - base !== 9) begin
            err_cnt++; $display("FAIL hold_second: clks=%0d data=%h rises=%0d required 36 7 9", n, rsp_data, rise_total - base);
        end
        ack_rsp();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int t, n, vs;
        tdo_const = 1'b0;
        send_cmd(2'b00, 6'd38, 38'h15_5555_5555);
        t = 0;
        while (rise_total - base < 14 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        vec_cnt++;
        if (rise_total - base !== 14) begin
            err_cnt++; $display("FAIL mid_reach_bit10: rises=%0d required 14", rise_total - base);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset_values");
        base = rise_total;
        reset = 1'b0;
        wait_tlr(n, vs);
        vec_cnt++;
        if (n !== 24 || rise_total - base !== 6 || vs !== 0) begin
            err_cnt++; $display("FAIL mid_tlr: clks=%0d rises=%0d rsp_valid_cycles=%0d required 24 6 0",
                                n, rise_total - base, vs);
        end
        vec_cnt++;
        if (tms_pattern(base, 6) !== 64'h1F || cmd_ready !== 1'b1) begin
            err_cnt++; $display("FAIL mid_tlr_tms: tms=%h cmd_ready=%b required 1f 1", tms_pattern(base, 6), cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_errors();
        test_tap_reset();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
